// File: rtl/seg7_scan_decoder.sv
// Display-bus monitor: recovers the hex nibble shown on each digit of a multiplexed,
// active-low 7-segment bus once the bus has been stable for STABLE_CYCLES samples.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DIGITS-1:0]     an_i,
    input  logic [6:0]            seg_i,
    input  logic                  clr_err_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic [DIGITS-1:0]     digit_valid_o,
    output logic                  upd_o,
    output logic [2:0]            upd_digit_o,
    output logic                  err_o,
    output logic                  err_sticky_o
);

    localparam int         SW      = DIGITS + 7;
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [SW-1:0]         s_q, s_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  captured_q, captured_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [DIGITS-1:0]     valid_q, valid_d;
    logic                  upd_q, upd_d;
    logic [2:0]            upd_digit_q, upd_digit_d;
    logic                  err_q, err_d;
    logic                  sticky_q, sticky_d;

    logic [DIGITS-1:0]     an_low;
    logic [6:0]            seg_s;
    logic [4:0]            gl;
    logic                  one_hot;
    logic                  capture;
    logic [2:0]            idx;

    // Returns {legal, nibble}; segments are g..a, active-low.
    function automatic logic [4:0] glyph(input logic [6:0] g);
        case (g)
            7'b1000000: glyph = 5'h10;
            7'b1111001: glyph = 5'h11;
            7'b0100100: glyph = 5'h12;
            7'b0110000: glyph = 5'h13;
            7'b0011001: glyph = 5'h14;
            7'b0010010: glyph = 5'h15;
            7'b0000010: glyph = 5'h16;
            7'b1111000: glyph = 5'h17;
            7'b0000000: glyph = 5'h18;
            7'b0010000: glyph = 5'h19;
            7'b0001000: glyph = 5'h1A;
            7'b0000011: glyph = 5'h1B;
            7'b1000110: glyph = 5'h1C;
            7'b0100001: glyph = 5'h1D;
            7'b0000110: glyph = 5'h1E;
            7'b0001110: glyph = 5'h1F;
            default:    glyph = 5'h00;
        endcase
    endfunction

    always_comb begin
        s_d         = {an_i, seg_i};
        cnt_d       = cnt_q;
        captured_d  = captured_q;
        value_d     = value_q;
        valid_d     = valid_q;
        upd_d       = 1'b0;
        upd_digit_d = upd_digit_q;
        err_d       = 1'b0;
        an_low      = ~s_q[SW-1:7];
        seg_s       = s_q[6:0];
        gl          = glyph(seg_s);
        one_hot     = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
        capture     = (cnt_q == CNT_MAX) && !captured_q;
        idx         = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_low[i]) idx = 3'(i);
        end

        // The window is judged on the sample about to be registered versus the one held.
        if (s_d != s_q) begin
            cnt_d      = 8'd0;
            captured_d = 1'b0;
        end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 8'd1;
            if (capture) captured_d = 1'b1;
        end

        if (capture) begin
            if (one_hot) begin
                if (gl[4]) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (an_low[i]) begin
                            value_d[4*i +: 4] = gl[3:0];
                            valid_d[i]        = 1'b1;
                        end
                    end
                    upd_d       = 1'b1;
                    upd_digit_d = idx;
                end else begin
                    err_d = 1'b1;
                    for (int i = 0; i < DIGITS; i++) begin
                        if (an_low[i]) valid_d[i] = 1'b0;
                    end
                end
            end else if (an_low != '0) begin
                err_d = 1'b1;
            end
        end

        sticky_d = err_d ? 1'b1 : (clr_err_i ? 1'b0 : sticky_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q         <= '1;
            cnt_q       <= 8'd0;
            captured_q  <= 1'b0;
            value_q     <= '0;
            valid_q     <= '0;
            upd_q       <= 1'b0;
            upd_digit_q <= 3'd0;
            err_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            captured_q  <= captured_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            upd_q       <= upd_d;
            upd_digit_q <= upd_digit_d;
            err_q       <= err_d;
            sticky_q    <= sticky_d;
        end
    end

    assign value_o       = value_q;
    assign digit_valid_o = valid_q;
    assign upd_o         = upd_q;
    assign upd_digit_o   = upd_digit_q;
    assign err_o         = err_q;
    assign err_sticky_o  = sticky_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder at default parameters (4 digits, 4-sample window).
module tb_seg7_scan_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  an_i;
    logic [6:0]  seg_i;
    logic        clr_err_i;
    logic [15:0] value_o;
    logic [3:0]  digit_valid_o;
    logic        upd_o;
    logic [2:0]  upd_digit_o;
    logic        err_o;
    logic        err_sticky_o;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_no, upd_cnt, err_cnt, both_cnt, last_upd_edge, last_err_edge;
    logic [2:0] last_upd_digit;

    localparam logic [6:0] G1 = 7'b1111001, G3 = 7'b0110000, GA = 7'b0001000;
    localparam logic [6:0] GC = 7'b1000110, GF = 7'b0001110, G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000, GD = 7'b0100001, BLANK = 7'b1111111;

    seg7_scan_decoder dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .an_i          (an_i),
        .seg_i         (seg_i),
        .clr_err_i     (clr_err_i),
        .value_o       (value_o),
        .digit_valid_o (digit_valid_o),
        .upd_o         (upd_o),
        .upd_digit_o   (upd_digit_o),
        .err_o         (err_o),
        .err_sticky_o  (err_sticky_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_counts();
        edge_no = 0; upd_cnt = 0; err_cnt = 0;
        last_upd_edge = -1; last_err_edge = -1;
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
            edge_no++;
            if (upd_o) begin
                upd_cnt++;
                last_upd_edge  = edge_no;
                last_upd_digit = upd_digit_o;
            end
            if (err_o) begin
                err_cnt++;
                last_err_edge = edge_no;
            end
            if (upd_o && err_o) both_cnt++;
        end
    endtask

    initial begin
        both_cnt = 0;
        last_upd_digit = 3'd0;
        clear_counts();

        // reset, then first capture on digit 0
        rst_i = 1'b1; clr_err_i = 1'b0; an_i = 4'b1110; seg_i = G1;
        hold(2);
        chk("rst_value", value_o, 32'h0);
        chk("rst_valid", digit_valid_o, 32'h0);
        chk("rst_upd", upd_o, 32'h0);
        chk("rst_upd_digit", upd_digit_o, 32'h0);
        chk("rst_err", err_o, 32'h0);
        chk("rst_sticky", err_sticky_o, 32'h0);
        rst_i = 1'b0;
        clear_counts();
        hold(10);
        chk("first_upd_count", upd_cnt, 32'd1);
        chk("first_upd_edge", last_upd_edge, 32'd5);
        chk("first_value", value_o[3:0], 32'h1);
        chk("first_valid", digit_valid_o, 32'b0001);

        // four-digit scan
        clear_counts(); an_i = 4'b1110; seg_i = G3; hold(6);
        chk("scan0_upd", upd_cnt, 32'd1);
        chk("scan0_digit", last_upd_digit, 32'd0);
        clear_counts(); an_i = 4'b1101; seg_i = GA; hold(6);
        chk("scan1_upd", upd_cnt, 32'd1);
        chk("scan1_digit", last_upd_digit, 32'd1);
        clear_counts(); an_i = 4'b1011; seg_i = GC; hold(6);
        chk("scan2_upd", upd_cnt, 32'd1);
        chk("scan2_digit", last_upd_digit, 32'd2);
        clear_counts(); an_i = 4'b0111; seg_i = GF; hold(6);
        chk("scan3_upd", upd_cnt, 32'd1);
        chk("scan3_digit", last_upd_digit, 32'd3);
        chk("scan_value", value_o, 32'hFCA3);
        chk("scan_valid", digit_valid_o, 32'b1111);

        // glitch filter: 8 for 3 cycles must never land
        clear_counts(); an_i = 4'b1110; seg_i = G8; hold(3);
        chk("glitch_no_upd", upd_cnt, 32'd0);
        chk("glitch_value_kept", value_o[3:0], 32'h3);
        seg_i = G9; hold(5);
        chk("glitch_upd", upd_cnt, 32'd1);
        chk("glitch_value", value_o, 32'hFCA9);

        // illegal glyph on digit 1, then multi-enable, then clear
        clear_counts(); an_i = 4'b1101; seg_i = GA; hold(5);
        chk("ill_pre_upd", upd_cnt, 32'd1);
        clear_counts(); seg_i = BLANK; hold(5);
        chk("ill_err", err_cnt, 32'd1);
        chk("ill_err_edge", last_err_edge, 32'd5);
        chk("ill_no_upd", upd_cnt, 32'd0);
        chk("ill_sticky", err_sticky_o, 32'h1);
        chk("ill_valid", digit_valid_o, 32'b1101);
        chk("ill_value", value_o, 32'hFCA9);
        clear_counts(); an_i = 4'b1100; seg_i = G1; hold(5);
        chk("multi_err", err_cnt, 32'd1);
        chk("multi_no_upd", upd_cnt, 32'd0);
        chk("multi_valid", digit_valid_o, 32'b1101);
        chk("multi_value", value_o, 32'hFCA9);
        clr_err_i = 1'b1; hold(1); clr_err_i = 1'b0;
        chk("clr_sticky", err_sticky_o, 32'h0);

        // clear coinciding with a new error: set wins
        clear_counts(); an_i = 4'b1011; seg_i = BLANK; hold(4);
        chk("coinc_no_err_yet", err_cnt, 32'd0);
        clr_err_i = 1'b1; hold(1); clr_err_i = 1'b0;
        chk("coinc_err", err_o, 32'h1);
        chk("coinc_sticky", err_sticky_o, 32'h1);
        chk("coinc_valid", digit_valid_o, 32'b1001);
        clr_err_i = 1'b1; hold(1); clr_err_i = 1'b0;
        chk("coinc_cleared", err_sticky_o, 32'h0);

        // blank bus, then reset in the middle of a window
        clear_counts(); an_i = 4'b1111; seg_i = G1; hold(20);
        chk("blank_upd", upd_cnt, 32'd0);
        chk("blank_err", err_cnt, 32'd0);
        chk("blank_sticky", err_sticky_o, 32'h0);
        clear_counts(); an_i = 4'b0111; seg_i = GD; hold(2);
        rst_i = 1'b1; hold(1); rst_i = 1'b0;
        chk("midrst_no_upd", upd_cnt, 32'd0);
        chk("midrst_value", value_o, 32'h0);
        chk("midrst_valid", digit_valid_o, 32'h0);
        clear_counts(); hold(10);
        chk("midrst_upd_count", upd_cnt, 32'd1);
        chk("midrst_upd_edge", last_upd_edge, 32'd5);
        chk("midrst_upd_digit", last_upd_digit, 32'd3);
        chk("midrst_value_after", value_o, 32'hD000);
        chk("midrst_valid_after", digit_valid_o, 32'b1000);

        chk("upd_err_exclusive", both_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
